// File: rtl/snn_timestep_scheduler.sv
// Timestep sequencer for the neuron array: snapshots parameters, sweeps a leak request over
// every neuron, waits for the spike router to drain, then advances the timestep.
module snn_timestep_scheduler #(
    parameter int unsigned NEURON_ADDR_WIDTH = 8,
    parameter int unsigned DRAIN_TIMEOUT     = 1024
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [31:0]                  ctrl_reg,
    input  logic [31:0]                  config_reg,
    input  logic [15:0]                  leak_rate,
    input  logic [15:0]                  threshold,
    input  logic [15:0]                  refractory_period,
    output logic [15:0]                  leak_rate_q,
    output logic [15:0]                  threshold_q,
    output logic [15:0]                  refractory_q,
    output logic                         nu_valid,
    input  logic                         nu_ready,
    output logic [NEURON_ADDR_WIDTH-1:0] nu_addr,
    input  logic                         router_idle,
    input  logic                         spike_in,
    output logic                         timestep_tick,
    output logic [31:0]                  status_reg,
    output logic [31:0]                  spike_count
);

    localparam int unsigned CntW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StLeak, StDrain, StNext, StDone} state_e;

    state_e                       r_state;
    logic                         r_start_d;
    logic [NEURON_ADDR_WIDTH-1:0] r_last;
    logic [15:0]                  r_num_ts;
    logic [15:0]                  r_timestep;
    logic [CntW-1:0]              r_drain_cnt;
    logic                         r_idle_seen;
    logic                         r_done;
    logic                         r_timeout;
    logic                         r_tick;
    logic                         r_valid;
    logic [NEURON_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                  r_spike_cnt;
    logic [15:0]                  r_leak_q;
    logic [15:0]                  r_thr_q;
    logic [15:0]                  r_refr_q;

    logic w_busy;
    logic w_start_edge;
    logic w_unused;

    assign w_busy       = (r_state == StLeak) || (r_state == StDrain) || (r_state == StNext);
    assign w_start_edge = ctrl_reg[0] && !r_start_d;
    assign w_unused     = ^{ctrl_reg[31:3], config_reg[31:16+NEURON_ADDR_WIDTH]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StIdle;
            r_start_d   <= 1'b0;
            r_last      <= '0;
            r_num_ts    <= '0;
            r_timestep  <= '0;
            r_drain_cnt <= '0;
            r_idle_seen <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_tick      <= 1'b0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_spike_cnt <= '0;
            r_leak_q    <= '0;
            r_thr_q     <= '0;
            r_refr_q    <= '0;
        end else begin
            r_start_d <= ctrl_reg[0];
            r_tick    <= 1'b0;
            if (w_busy && spike_in && (r_spike_cnt != 32'hFFFF_FFFF)) begin
                r_spike_cnt <= r_spike_cnt + 32'd1;
            end
            if (ctrl_reg[1]) begin
                // Soft clear wins over everything, including a simultaneous start edge.
                r_state     <= StIdle;
                r_valid     <= 1'b0;
                r_done      <= 1'b0;
                r_timeout   <= 1'b0;
                r_timestep  <= '0;
                r_spike_cnt <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_start_edge) begin
                            r_leak_q    <= leak_rate;
                            r_thr_q     <= threshold;
                            r_refr_q    <= refractory_period;
                            r_last      <= config_reg[16 +: NEURON_ADDR_WIDTH];
                            r_num_ts    <= (config_reg[15:0] == 16'd0) ? 16'd1 : config_reg[15:0];
                            r_spike_cnt <= '0;
                            r_timestep  <= '0;
                            r_addr      <= '0;
                            r_valid     <= 1'b1;
                            r_done      <= 1'b0;
                            r_timeout   <= 1'b0;
                            r_state     <= StLeak;
                        end
                    end
                    StLeak: begin
                        if (r_valid && nu_ready) begin
                            if (r_addr == r_last) begin
                                r_valid     <= 1'b0;
                                r_drain_cnt <= '0;
                                r_idle_seen <= 1'b0;
                                r_state     <= StDrain;
                            end else begin
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                        r_idle_seen <= router_idle;
                        // Tick and timestep update land together in the NEXT cycle.
                        if (router_idle && r_idle_seen) begin
                            r_tick     <= 1'b1;
                            r_timestep <= r_timestep + 16'd1;
                            r_state    <= StNext;
                        end else if (r_drain_cnt == DrainLast) begin
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= StDone;
                        end
                    end
                    StNext: begin
                        if ((r_timestep == r_num_ts) && !ctrl_reg[2]) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            if (r_timestep == r_num_ts) begin
                                r_timestep <= '0;
                            end
                            r_addr  <= '0;
                            r_valid <= 1'b1;
                            r_state <= StLeak;
                        end
                    end
                    StDone: begin
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign leak_rate_q   = r_leak_q;
    assign threshold_q   = r_thr_q;
    assign refractory_q  = r_refr_q;
    assign nu_valid      = r_valid;
    assign nu_addr       = r_addr;
    assign timestep_tick = r_tick;
    assign spike_count   = r_spike_cnt;
    assign status_reg    = {r_timestep, 13'd0, r_timeout, r_done, w_busy};

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler: a linear sequence of steps with hand-computed
// expectations checked by immediate assertions.
module tb_snn_timestep_scheduler;

    logic        aclk;
    logic        aresetn;
    logic [31:0] ctrl_reg;
    logic [31:0] config_reg;
    logic [15:0] leak_rate;
    logic [15:0] threshold;
    logic [15:0] refractory_period;
    logic [15:0] leak_rate_q;
    logic [15:0] threshold_q;
    logic [15:0] refractory_q;
    logic        nu_valid;
    logic        nu_ready;
    logic [7:0]  nu_addr;
    logic        router_idle;
    logic        spike_in;
    logic        timestep_tick;
    logic [31:0] status_reg;
    logic [31:0] spike_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] addr_log[$];
    int         tick_total = 0;

    snn_timestep_scheduler #(
        .NEURON_ADDR_WIDTH(8),
        .DRAIN_TIMEOUT    (16)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .ctrl_reg         (ctrl_reg),
        .config_reg       (config_reg),
        .leak_rate        (leak_rate),
        .threshold        (threshold),
        .refractory_period(refractory_period),
        .leak_rate_q      (leak_rate_q),
        .threshold_q      (threshold_q),
        .refractory_q     (refractory_q),
        .nu_valid         (nu_valid),
        .nu_ready         (nu_ready),
        .nu_addr          (nu_addr),
        .router_idle      (router_idle),
        .spike_in         (spike_in),
        .timestep_tick    (timestep_tick),
        .status_reg       (status_reg),
        .spike_count      (spike_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Record accepted leak requests and tick pulses as seen at the active edge.
    always @(posedge aclk) begin
        if (aresetn && nu_valid && nu_ready) addr_log.push_back(nu_addr);
        if (aresetn && timestep_tick) tick_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic chk_log(input string tag, input int base, input int nexp, input int mod);
        chk({tag, "_len"}, 32'(addr_log.size() - base), 32'(nexp));
        for (int i = 0; i < nexp && (base + i) < addr_log.size(); i++) begin
            chk($sformatf("%s_%0d", tag, i), {24'd0, addr_log[base+i]}, 32'(i % mod));
        end
    endtask

    initial begin
        int lb;
        int tb0;
        aresetn           = 1'b0;
        ctrl_reg          = '0;
        config_reg        = '0;
        leak_rate         = 16'h1111;
        threshold         = 16'h2222;
        refractory_period = 16'h0033;
        nu_ready          = 1'b1;
        router_idle       = 1'b1;
        spike_in          = 1'b0;
        step(2);
        chk("rst_status", status_reg, 32'h0);
        chk("rst_spikes", spike_count, 32'h0);
        chk("rst_valid", {31'd0, nu_valid}, 32'h0);
        chk("rst_addr", {24'd0, nu_addr}, 32'h0);
        chk("rst_tick", {31'd0, timestep_tick}, 32'h0);
        chk("rst_snap", {leak_rate_q, threshold_q}, 32'h0);
        aresetn = 1'b1;
        step(1);

        // Basic run: last=3, two timesteps, always ready and idle.
        lb = addr_log.size();
        tb0 = tick_total;
        config_reg = 32'h0003_0002;
        ctrl_reg   = 32'h1;
        step(1);
        ctrl_reg  = 32'h0;
        leak_rate = 16'h9999;
        chk("start_status", status_reg, 32'h0000_0001);
        chk("start_valid", {31'd0, nu_valid}, 32'h1);
        chk("start_addr", {24'd0, nu_addr}, 32'h0);
        step(6);
        chk("ts1_tick", {31'd0, timestep_tick}, 32'h1);
        chk("ts1_status", status_reg, 32'h0001_0001);
        step(8);
        chk("run1_done", status_reg, 32'h0002_0002);
        chk("run1_ticks", 32'(tick_total - tb0), 32'd2);
        chk_log("run1_addr", lb, 8, 4);
        step(1);
        chk("run1_sticky", status_reg, 32'h0002_0002);
        chk("snap_leak", {16'd0, leak_rate_q}, 32'h1111);
        chk("snap_thr_refr", {threshold_q, refractory_q}, 32'h2222_0033);

        // Handshake stalls: address must hold, nothing skipped or repeated.
        lb = addr_log.size();
        config_reg = 32'h0003_0001;
        nu_ready   = 1'b0;
        ctrl_reg   = 32'h1;
        step(1);
        ctrl_reg = 32'h0;
        step(1);
        chk("stall_addr0", {24'd0, nu_addr}, 32'h0);
        chk("stall_valid", {31'd0, nu_valid}, 32'h1);
        nu_ready = 1'b1;
        step(1);
        nu_ready = 1'b0;
        step(2);
        chk("stall_addr1", {24'd0, nu_addr}, 32'h1);
        nu_ready = 1'b1;
        step(6);
        chk("stall_done", status_reg, 32'h0001_0002);
        chk_log("stall_addr", lb, 4, 4);
        step(1);

        // Drain timeout: router never idles.
        tb0 = tick_total;
        router_idle = 1'b0;
        config_reg  = 32'h0001_0003;
        ctrl_reg    = 32'h1;
        step(1);
        ctrl_reg = 32'h0;
        step(17);
        chk("drain_last", status_reg, 32'h0000_0001);
        step(1);
        chk("timeout", status_reg, 32'h0000_0006);
        chk("timeout_ticks", 32'(tick_total - tb0), 32'd0);
        step(1);
        router_idle = 1'b1;

        // Spike counting: only while busy.
        config_reg = 32'h0007_0002;
        ctrl_reg   = 32'h1;
        step(1);
        ctrl_reg = 32'h0;
        chk("spk_start", status_reg, 32'h0000_0001);
        spike_in = 1'b1;
        step(5);
        spike_in = 1'b0;
        chk("spk_run", spike_count, 32'd5);
        step(20);
        spike_in = 1'b1;
        step(3);
        spike_in = 1'b0;
        step(1);
        chk("spk_idle", spike_count, 32'd5);
        chk("spk_done", status_reg, 32'h0002_0002);

        // Saturation near the top of the counter.
        ctrl_reg = 32'h1;
        step(1);
        ctrl_reg = 32'h0;
        step(1);
        force dut.r_spike_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_spike_cnt;
        spike_in = 1'b1;
        step(3);
        spike_in = 1'b0;
        chk("spk_sat", spike_count, 32'hFFFF_FFFF);
        step(25);
        chk("sat_done", status_reg, 32'h0002_0002);

        // Continuous mode with num_timesteps=0 (acts as 1).
        tb0 = tick_total;
        config_reg = 32'h0001_0000;
        ctrl_reg   = 32'h5;
        step(1);
        ctrl_reg = 32'h4;
        step(4);
        chk("cont_tick1", {31'd0, timestep_tick}, 32'h1);
        chk("cont_next", status_reg, 32'h0001_0001);
        step(1);
        chk("cont_wrap", status_reg, 32'h0000_0001);
        chk("cont_relaunch", {23'd0, nu_valid, nu_addr}, 32'h0000_0100);
        step(4);
        chk("cont_tick2", {31'd0, timestep_tick}, 32'h1);
        step(1);
        ctrl_reg = 32'h0;
        step(4);
        chk("cont_tick3", {31'd0, timestep_tick}, 32'h1);
        step(1);
        chk("cont_done", status_reg, 32'h0001_0002);
        chk("cont_ticks", 32'(tick_total - tb0), 32'd3);
        step(1);

        // Soft clear mid-LEAK with start also rising.
        config_reg = 32'h0007_0002;
        ctrl_reg   = 32'h1;
        step(1);
        ctrl_reg = 32'h0;
        spike_in = 1'b1;
        step(2);
        spike_in = 1'b0;
        chk("clr_pre_spk", spike_count, 32'd2);
        ctrl_reg = 32'h3;
        step(1);
        chk("clr_valid", {31'd0, nu_valid}, 32'h0);
        chk("clr_spk", spike_count, 32'h0);
        chk("clr_status", status_reg, 32'h0);
        ctrl_reg = 32'h1;
        step(2);
        chk("clr_norestart", {31'd0, nu_valid}, 32'h0);
        chk("clr_idle", status_reg, 32'h0);
        chk("clr_snap", {16'd0, leak_rate_q}, 32'h9999);
        ctrl_reg = 32'h0;
        step(1);

        // Asynchronous reset mid-DRAIN.
        router_idle = 1'b0;
        config_reg  = 32'h0001_0001;
        ctrl_reg    = 32'h1;
        step(1);
        ctrl_reg = 32'h0;
        step(3);
        chk("pre_rst_drain", {status_reg[15:0], 8'd0, nu_addr}, 32'h0001_0001);
        aresetn = 1'b0;
        #1;
        chk("arst_status", status_reg, 32'h0);
        chk("arst_addr_valid", {23'd0, nu_valid, nu_addr}, 32'h0);
        chk("arst_snap", {leak_rate_q, refractory_q}, 32'h0);
        chk("arst_spk_tick", spike_count | {31'd0, timestep_tick}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
